wb_stage_buf: RTL and testbench

Parametrised write-back stage for the 5-stage LoongArch pipeline. It latches the MEM-stage result under a valid/allowin handshake and extracts and extends sub-word load data. It commits the register-file write, and pushes a retire-trace record into an internal FIFO. The FIFO drains to the difftest/trace monitor with backpressure, and a full FIFO stalls the pipeline.

---
 rtl/wb_stage_buf.sv | 148 ++++++++++++++
 tb/tb_wb_stage_buf.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_buf.sv
// Write-back stage: latches the MEM result, extracts sub-word load data, commits the
// register-file write and queues one retire-trace record per committed instruction.
module wb_stage_buf #(
   parameter int TRACE_DEPTH = 4,
   parameter int RF_ADDR_W   = 5,
   parameter int TRACE_WEN_W = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               ms_valid,
   output logic                               ws_allowin,
   input  logic [31:0]                        ms_pc,
   input  logic                               ms_res_from_mem,
   input  logic                               ms_gr_we,
   input  logic [RF_ADDR_W-1:0]               ms_dest,
   input  logic [31:0]                        ms_alu_result,
   input  logic [2:0]                         ms_mem_op,
   input  logic [31:0]                        read_data,
   input  logic                               flush,
   output logic                               rf_wen,
   output logic [RF_ADDR_W-1:0]               rf_waddr,
   output logic [31:0]                        rf_wdata,
   output logic                               trace_valid,
   input  logic                               trace_ready,
   output logic [31:0]                        trace_pc,
   output logic [TRACE_WEN_W-1:0]             trace_wen,
   output logic [RF_ADDR_W-1:0]               trace_waddr,
   output logic [31:0]                        trace_wdata,
   output logic [$clog2(TRACE_DEPTH+1)-1:0]   trace_count
);
   localparam int CNT_W = $clog2(TRACE_DEPTH + 1);
   localparam int PTR_W = $clog2(TRACE_DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TRACE_DEPTH);

   logic                 ws_valid;
   logic [31:0]          ws_pc;
   logic                 ws_res_from_mem;
   logic                 ws_gr_we;
   logic [RF_ADDR_W-1:0] ws_dest;
   logic [31:0]          ws_alu_result;
   logic [2:0]           ws_mem_op;
   logic [31:0]          ws_rdata;

   logic                 ws_ready_go;
   logic                 commit;
   logic                 push;
   logic                 pop;
   logic [7:0]           lane_b;
   logic [15:0]          lane_h;
   logic [31:0]          load_data;

   logic [31:0]          fifo_pc    [TRACE_DEPTH];
   logic [RF_ADDR_W-1:0] fifo_waddr [TRACE_DEPTH];
   logic [31:0]          fifo_wdata [TRACE_DEPTH];
   logic                 fifo_wen   [TRACE_DEPTH];
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W-1:0]     wr_ptr;
   logic [CNT_W-1:0]     count;

   // A full FIFO only stalls WB when the head cannot drain on the same edge.
   assign ws_ready_go = (count < DEPTH_C) | trace_ready;
   assign ws_allowin  = ~ws_valid | ws_ready_go;
   assign commit      = ws_valid & ws_ready_go & ~flush;
   assign trace_valid = (count != '0);
   assign push        = commit;
   assign pop         = trace_valid & trace_ready;
   assign trace_count = count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ws_valid        <= 1'b0;
         ws_pc           <= '0;
         ws_res_from_mem <= 1'b0;
         ws_gr_we        <= 1'b0;
         ws_dest         <= '0;
         ws_alu_result   <= '0;
         ws_mem_op       <= '0;
         ws_rdata        <= '0;
      end else begin
         if (ms_valid && ws_allowin) begin
            ws_valid        <= 1'b1;
            ws_pc           <= ms_pc;
            ws_res_from_mem <= ms_res_from_mem;
            ws_gr_we        <= ms_gr_we;
            ws_dest         <= ms_dest;
            ws_alu_result   <= ms_alu_result;
            ws_mem_op       <= ms_mem_op;
            ws_rdata        <= read_data;
         end else if (ws_allowin || flush) begin
            ws_valid <= 1'b0;
         end
      end
   end

   always_comb begin
      lane_b = ws_rdata[7:0];
      unique case (ws_alu_result[1:0])
         2'd0: lane_b = ws_rdata[7:0];
         2'd1: lane_b = ws_rdata[15:8];
         2'd2: lane_b = ws_rdata[23:16];
         2'd3: lane_b = ws_rdata[31:24];
      endcase
      lane_h = ws_alu_result[1] ? ws_rdata[31:16] : ws_rdata[15:0];
      unique case (ws_mem_op)
         3'b001:  load_data = {{24{lane_b[7]}}, lane_b};
         3'b010:  load_data = {24'h0, lane_b};
         3'b011:  load_data = {{16{lane_h[15]}}, lane_h};
         3'b100:  load_data = {16'h0, lane_h};
         default: load_data = ws_rdata;
      endcase
   end

   assign rf_wen   = commit & ws_gr_we;
   assign rf_waddr = ws_dest;
   assign rf_wdata = ws_res_from_mem ? load_data : ws_alu_result;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[wr_ptr]    <= ws_pc;
         fifo_wen[wr_ptr]   <= rf_wen;
         fifo_waddr[wr_ptr] <= ws_dest;
         fifo_wdata[wr_ptr] <= rf_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Head data is forced to zero while empty so stale storage never leaks out.
   assign trace_pc    = trace_valid ? fifo_pc[rd_ptr] : '0;
   assign trace_wen   = (trace_valid && fifo_wen[rd_ptr]) ? '1 : '0;
   assign trace_waddr = trace_valid ? fifo_waddr[rd_ptr] : '0;
   assign trace_wdata = trace_valid ? fifo_wdata[rd_ptr] : '0;

endmodule

// File: tb/tb_wb_stage_buf.sv
// Scoreboard bench for wb_stage_buf: expected RF writes and trace records are queued at
// issue time from a behavioural model and checked by an independent monitor.
module tb_wb_stage_buf;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ms_valid = 1'b0, ms_res_from_mem = 1'b0, ms_gr_we = 1'b0;
   logic [31:0] ms_pc = '0, ms_alu_result = '0, read_data = '0;
   logic [4:0]  ms_dest = '0;
   logic [2:0]  ms_mem_op = '0;
   logic        flush = 1'b0, trace_ready = 1'b0;
   logic        ws_allowin, rf_wen, trace_valid;
   logic [4:0]  rf_waddr, trace_waddr;
   logic [31:0] rf_wdata, trace_pc, trace_wdata;
   logic [3:0]  trace_wen;
   logic [2:0]  trace_count;

   always #5 clk = ~clk;

   wb_stage_buf #(.TRACE_DEPTH(DEPTH), .RF_ADDR_W(5), .TRACE_WEN_W(4)) dut (
      .clk(clk), .rst(rst), .ms_valid(ms_valid), .ws_allowin(ws_allowin),
      .ms_pc(ms_pc), .ms_res_from_mem(ms_res_from_mem), .ms_gr_we(ms_gr_we),
      .ms_dest(ms_dest), .ms_alu_result(ms_alu_result), .ms_mem_op(ms_mem_op),
      .read_data(read_data), .flush(flush), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata), .trace_valid(trace_valid), .trace_ready(trace_ready),
      .trace_pc(trace_pc), .trace_wen(trace_wen), .trace_waddr(trace_waddr),
      .trace_wdata(trace_wdata), .trace_count(trace_count));

   typedef struct {
      logic [31:0] pc;
      logic [3:0]  wen;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } rec_t;

   rec_t exp_tr[$];
   rec_t exp_rf[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   m_cnt = 0, m_cnt_nxt = 0;
   bit   m_occ = 0, m_occ_nxt = 0, m_gwe = 0, m_gwe_nxt = 0;
   bit   m_allow = 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] load_val(input logic [2:0] op, input logic [1:0] a,
                                            input logic [31:0] rd);
      logic [31:0] b, h;
      b = (rd >> (8 * a)) & 32'hFF;
      h = (rd >> (16 * a[1])) & 32'hFFFF;
      case (op)
         3'd1:    return (b > 32'h7F) ? (b | 32'hFFFFFF00) : b;
         3'd2:    return b;
         3'd3:    return (h > 32'h7FFF) ? (h | 32'hFFFF0000) : h;
         3'd4:    return h;
         default: return rd;
      endcase
   endfunction

   // One clock cycle: drive inputs, advance the occupancy model, queue expectations.
   task automatic cycle(input bit v, input logic [31:0] pc, input bit rfm, input bit gwe,
                        input logic [4:0] dest, input logic [31:0] alu, input logic [2:0] op,
                        input logic [31:0] rd, input bit fl, input bit tr, output bit acc);
      bit   rgo, commit, pop;
      rec_t r;
      @(posedge clk); #1;
      m_cnt = m_cnt_nxt; m_occ = m_occ_nxt; m_gwe = m_gwe_nxt;
      ms_valid = v; ms_pc = pc; ms_res_from_mem = rfm; ms_gr_we = gwe; ms_dest = dest;
      ms_alu_result = alu; ms_mem_op = op; read_data = rd; flush = fl; trace_ready = tr;
      rgo     = (m_cnt < DEPTH) || tr;
      m_allow = !m_occ || rgo;
      commit  = m_occ && rgo && !fl;
      pop     = (m_cnt != 0) && tr;
      acc     = v && m_allow;
      if (fl && m_occ) begin
         r = exp_tr.pop_back();
         if (m_gwe) r = exp_rf.pop_back();
      end
      if (acc) begin
         r.pc = pc; r.wen = gwe ? 4'hF : 4'h0; r.waddr = dest;
         r.wdata = rfm ? load_val(op, alu[1:0], rd) : alu;
         exp_tr.push_back(r);
         if (gwe) exp_rf.push_back(r);
      end
      m_cnt_nxt = m_cnt + int'(commit) - int'(pop);
      m_occ_nxt = acc || (m_occ && !commit && !fl);
      m_gwe_nxt = acc ? gwe : m_gwe;
   endtask

   task automatic idle(input int n, input bit tr);
      bit a;
      for (int i = 0; i < n; i++) cycle(0, '0, 0, 0, '0, '0, '0, '0, 0, tr, a);
   endtask

   task automatic send(input logic [31:0] pc, input bit rfm, input bit gwe, input logic [4:0] dest,
                       input logic [31:0] alu, input logic [2:0] op, input logic [31:0] rd,
                       input bit tr);
      bit a;
      int k = 0;
      do begin
         cycle(1, pc, rfm, gwe, dest, alu, op, rd, 0, tr, a);
         k++;
      end while (!a && k < 50);
      n_checks++;
      if (!a) begin
         n_fail++;
         $display("FAIL send_timeout: pc %h not accepted within 50 cycles", pc);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_trace_valid"}, trace_valid, 0);
      check({tag, "_trace_count"}, trace_count, 0);
      check({tag, "_trace_pc"}, trace_pc, 0);
      check({tag, "_trace_wdata"}, trace_wdata, 0);
      check({tag, "_rf_wen"}, rf_wen, 0);
      check({tag, "_allowin"}, ws_allowin, 1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 0; ms_valid = 0; flush = 0; trace_ready = 0;
      #1;
      check_reset_state("midrst");
      exp_tr.delete(); exp_rf.delete();
      m_cnt = 0; m_cnt_nxt = 0; m_occ = 0; m_occ_nxt = 0; m_allow = 1;
      @(posedge clk); #1;
      rst = 1;
   endtask

   // Monitor: pops expectations whenever the DUT writes the RF or hands off a trace record.
   always @(negedge clk) begin
      rec_t r;
      if (rst) begin
         check("allowin", ws_allowin, m_allow);
         check("trace_count", trace_count, m_cnt);
         check("trace_valid", trace_valid, m_cnt != 0);
         if (rf_wen) begin
            if (exp_rf.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL rf_unexpected: waddr %h wdata %h, none expected", rf_waddr, rf_wdata);
            end else begin
               r = exp_rf.pop_front();
               check("rf_waddr", rf_waddr, r.waddr);
               check("rf_wdata", rf_wdata, r.wdata);
            end
         end
         if (trace_valid && trace_ready) begin
            if (exp_tr.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL trace_unexpected: pc %h, none expected", trace_pc);
            end else begin
               r = exp_tr.pop_front();
               check("trace_pc", trace_pc, r.pc);
               check("trace_wen", trace_wen, r.wen);
               check("trace_waddr", trace_waddr, r.waddr);
               check("trace_wdata", trace_wdata, r.wdata);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          a;
      logic [31:0] pc, alu, rd;
      logic [4:0]  dest;
      logic [2:0]  op;
      bit          rfm, gwe, v;
      #1;
      check_reset_state("reset");
      #20 rst = 1;

      // Back-to-back ALU results
      send(32'h1c000000, 0, 1, 5'd1, 32'h11, 3'd0, '0, 1);
      send(32'h1c000004, 0, 1, 5'd2, 32'h22, 3'd0, '0, 1);
      send(32'h1c000008, 0, 1, 5'd3, 32'h33, 3'd0, '0, 1);
      idle(3, 1);

      // Sub-word loads from one data word
      send(32'h1c000100, 1, 1, 5'd4, 32'h1000_0003, 3'd1, 32'h80FF7F01, 1);
      send(32'h1c000104, 1, 1, 5'd5, 32'h1000_0001, 3'd2, 32'h80FF7F01, 1);
      send(32'h1c000108, 1, 1, 5'd6, 32'h1000_0002, 3'd3, 32'h80FF7F01, 1);
      send(32'h1c00010c, 1, 1, 5'd7, 32'h1000_0000, 3'd4, 32'h80FF7F01, 1);
      send(32'h1c000110, 1, 1, 5'd8, 32'h1000_0000, 3'd0, 32'h80FF7F01, 1);
      idle(3, 1);

      // Backpressure: fifth instruction stalls behind a full FIFO
      for (int i = 0; i < 5; i++)
         send(32'h1c000200 + 4 * i, 0, 1, 5'(9 + i), 32'h100 + i, 3'd0, '0, 0);
      idle(3, 0);
      check("bp_full_count", trace_count, DEPTH);
      check("bp_full_allowin", ws_allowin, 0);
      check("bp_full_rf_wen", rf_wen, 0);
      idle(1, 1);
      idle(1, 0);
      check("bp_after_pop_count", trace_count, DEPTH);
      idle(6, 1);

      // Store/branch: no RF write, trace record with wen=0
      send(32'h1c000010, 0, 0, 5'd0, 32'hDEAD0000, 3'd0, '0, 1);
      idle(3, 1);

      // Flush the load in WB while the next instruction is accepted
      send(32'h1c000300, 1, 1, 5'd5, 32'h2000_0000, 3'd0, 32'hCAFEF00D, 1);
      cycle(1, 32'h1c000304, 0, 1, 5'd6, 32'h66, 3'd0, '0, 1, 1, a);
      check("flush_accept", a, 1);
      idle(4, 1);

      // Reset with three pending records
      for (int i = 0; i < 3; i++)
         send(32'h1c000400 + 4 * i, 0, 1, 5'(20 + i), 32'h400 + i, 3'd0, '0, 0);
      idle(2, 0);
      check("prerst_count", trace_count, 3);
      do_reset();
      idle(2, 1);

      // Randomised traffic with held offers, random backpressure and flushes
      v = 0; pc = '0; rfm = 0; gwe = 0; dest = '0; alu = '0; op = '0; rd = '0; a = 1;
      for (int i = 0; i < 500; i++) begin
         if (a || !v) begin
            v = ($urandom_range(0, 3) != 0);
            pc = 32'h1c000000 + ($urandom & 32'hFFFC);
            rfm = $urandom_range(0, 1) == 1;
            gwe = $urandom_range(0, 3) != 0;
            dest = 5'($urandom);
            alu = $urandom; op = 3'($urandom); rd = $urandom;
         end
         cycle(v, pc, rfm, gwe, dest, alu, op, rd, $urandom_range(0, 9) == 0,
               $urandom_range(0, 2) != 0, a);
      end
      idle(10, 1);
      check("drain_trace_queue", exp_tr.size(), 0);
      check("drain_rf_queue", exp_rf.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
